// File: rtl/rhythm_pkg.sv
// Shared types for the rhythm note scheduler: FSM states, chart entry layout,
// keycode constants and a saturating-add helper.
package rhythm_pkg;

    localparam int CHART_FRAME_W = 12;

    localparam logic [7:0] KEY_START = 8'h2c;
    localparam logic [7:0] KEY_IDLE  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [CHART_FRAME_W-1:0] frame;
        logic [1:0]               lane;
    } chart_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/rhythm_note_scheduler_if.sv
// Signal bundle between the keyboard/lane-dropper side (master) and the
// scheduler (slave).
interface rhythm_note_scheduler_if #(
    parameter int NUM_LANES = 4,
    parameter int FRAME_W   = 12
);
    logic [7:0]           keycode;
    logic [NUM_LANES-1:0] lane_hit;
    logic [NUM_LANES-1:0] lane_miss;
    logic [NUM_LANES-1:0] launch;
    logic [NUM_LANES-1:0] lane_busy;
    logic [FRAME_W-1:0]   frame_cnt;
    logic [15:0]          score;
    logic [7:0]           combo;
    logic [7:0]           miss_cnt;
    logic                 done;

    modport master (
        output keycode, lane_hit, lane_miss,
        input  launch, lane_busy, frame_cnt, score, combo, miss_cnt, done
    );

    modport slave (
        input  keycode, lane_hit, lane_miss,
        output launch, lane_busy, frame_cnt, score, combo, miss_cnt, done
    );
endinterface

// File: rtl/rhythm_note_scheduler_chart_rom.sv
// Song chart: combinational lookup from chart index to (launch frame, lane).
// Entries must stay non-decreasing in frame.
module chart_rom
    import rhythm_pkg::*;
#(
    parameter int CHART_LEN = 32
) (
    input  logic [7:0]   idx_i,
    output chart_entry_t entry_o
);

    always_comb begin
        entry_o = '0;
        if (int'(idx_i) < CHART_LEN) begin
            case (idx_i)
                8'd0:  entry_o = chart_entry_t'{12'd5,   2'd0};
                8'd1:  entry_o = chart_entry_t'{12'd5,   2'd1};
                8'd2:  entry_o = chart_entry_t'{12'd10,  2'd0};
                8'd3:  entry_o = chart_entry_t'{12'd20,  2'd2};
                8'd4:  entry_o = chart_entry_t'{12'd24,  2'd3};
                8'd5:  entry_o = chart_entry_t'{12'd28,  2'd0};
                8'd6:  entry_o = chart_entry_t'{12'd40,  2'd1};
                8'd7:  entry_o = chart_entry_t'{12'd44,  2'd1};
                8'd8:  entry_o = chart_entry_t'{12'd46,  2'd3};
                8'd9:  entry_o = chart_entry_t'{12'd60,  2'd0};
                8'd10: entry_o = chart_entry_t'{12'd64,  2'd1};
                8'd11: entry_o = chart_entry_t'{12'd68,  2'd2};
                8'd12: entry_o = chart_entry_t'{12'd72,  2'd3};
                8'd13: entry_o = chart_entry_t'{12'd80,  2'd0};
                8'd14: entry_o = chart_entry_t'{12'd80,  2'd2};
                8'd15: entry_o = chart_entry_t'{12'd88,  2'd1};
                8'd16: entry_o = chart_entry_t'{12'd96,  2'd3};
                8'd17: entry_o = chart_entry_t'{12'd104, 2'd0};
                8'd18: entry_o = chart_entry_t'{12'd112, 2'd1};
                8'd19: entry_o = chart_entry_t'{12'd120, 2'd2};
                8'd20: entry_o = chart_entry_t'{12'd128, 2'd3};
                8'd21: entry_o = chart_entry_t'{12'd136, 2'd0};
                8'd22: entry_o = chart_entry_t'{12'd136, 2'd3};
                8'd23: entry_o = chart_entry_t'{12'd144, 2'd1};
                8'd24: entry_o = chart_entry_t'{12'd152, 2'd2};
                8'd25: entry_o = chart_entry_t'{12'd160, 2'd0};
                8'd26: entry_o = chart_entry_t'{12'd168, 2'd3};
                8'd27: entry_o = chart_entry_t'{12'd176, 2'd1};
                8'd28: entry_o = chart_entry_t'{12'd184, 2'd2};
                8'd29: entry_o = chart_entry_t'{12'd192, 2'd0};
                8'd30: entry_o = chart_entry_t'{12'd200, 2'd3};
                8'd31: entry_o = chart_entry_t'{12'd208, 2'd1};
                default: entry_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/rhythm_note_scheduler.sv
// Song sequencer: walks the chart, launches arrows into free lanes, and keeps
// score/combo/miss totals from the hit and miss pulses the lanes return.
module rhythm_note_scheduler
    import rhythm_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int CHART_LEN  = 32,
    parameter int FRAME_W    = 12,
    parameter int HIT_POINTS = 10
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    rhythm_note_scheduler_if.slave  bus
);

    state_e               state_q, state_d;
    logic [8:0]           ptr_q, ptr_d;
    logic [NUM_LANES-1:0] busy_q, busy_d;
    logic [NUM_LANES-1:0] launch_q, launch_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [15:0]          score_q, score_d;
    logic [7:0]           combo_q, combo_d;
    logic [7:0]           miss_q, miss_d;
    logic                 done_q, done_d;

    chart_entry_t         entry;
    logic [NUM_LANES-1:0] hit_v, miss_v, lane_oh;
    logic [31:0]          n_hit, n_miss;
    logic                 issue, skip;

    chart_rom #(.CHART_LEN(CHART_LEN)) u_chart_rom (
        .idx_i   (ptr_q[7:0]),
        .entry_o (entry)
    );

    // A lane reporting hit and miss together counts only as a hit.
    always_comb begin
        hit_v  = bus.lane_hit & busy_q;
        miss_v = bus.lane_miss & busy_q & ~bus.lane_hit;
        n_hit  = '0;
        n_miss = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_hit  = n_hit + 32'(hit_v[i]);
            n_miss = n_miss + 32'(miss_v[i]);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        launch_d = '0;
        frame_d  = frame_q;
        score_d  = score_q;
        combo_d  = combo_q;
        miss_d   = miss_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        skip     = 1'b0;
        lane_oh  = NUM_LANES'(1) << entry.lane;

        case (state_q)
            ST_IDLE: begin
                if (bus.keycode == KEY_START) state_d = ST_RUN;
            end
            ST_RUN: begin
                frame_d = (&frame_q) ? frame_q : frame_q + 1'b1;
                if (32'(entry.frame) <= 32'(frame_q)) begin
                    issue = 1'b1;
                    skip  = busy_q[entry.lane];
                    ptr_d = ptr_q + 9'd1;
                    if (ptr_q == 9'(CHART_LEN - 1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (busy_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.keycode == KEY_IDLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_RUN || state_q == ST_DRAIN) begin
            score_d = 16'(sat_add(32'(score_q), 32'(HIT_POINTS) * n_hit, 32'hFFFF));
            combo_d = 8'(sat_add(((n_miss != 0) || skip) ? 32'd0 : 32'(combo_q), n_hit, 32'd255));
            miss_d  = 8'(sat_add(32'(miss_q), n_miss + 32'(skip), 32'd255));
            // Issue decisions use the registered busy, so a same-cycle
            // return and re-issue on one lane is a skip that leaves it clear.
            busy_d  = busy_q & ~(bus.lane_hit | bus.lane_miss);
            if (issue && !skip) begin
                busy_d   = busy_d | lane_oh;
                launch_d = lane_oh;
            end
        end

        // Results clear on the way back to IDLE so the HUD shows a fresh song.
        if (state_d == ST_IDLE) begin
            ptr_d    = '0;
            busy_d   = '0;
            launch_d = '0;
            frame_d  = '0;
            score_d  = '0;
            combo_d  = '0;
            miss_d   = '0;
        end

        done_d = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            busy_q   <= '0;
            launch_q <= '0;
            frame_q  <= '0;
            score_q  <= '0;
            combo_q  <= '0;
            miss_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            launch_q <= launch_d;
            frame_q  <= frame_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            miss_q   <= miss_d;
            done_q   <= done_d;
        end
    end

    assign bus.launch    = launch_q;
    assign bus.lane_busy = busy_q;
    assign bus.frame_cnt = frame_q;
    assign bus.score     = score_q;
    assign bus.combo     = combo_q;
    assign bus.miss_cnt  = miss_q;
    assign bus.done      = done_q;

endmodule
